tmcu_apb_uart: RTL and testbench

TMCU_APB_UART -- requirements
Module: tmcu_apb_uart

---
 rtl/tmcu_pkg.sv | 37 +++
 rtl/tmcu_sync_fifo.sv | 79 +++++++
 rtl/tmcu_apb_uart.sv | 177 +++++++++++++++++
 tb/tb_tmcu_apb_uart.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmcu_pkg.sv
// -----------------------------------------------------------------------------
// tmcu_pkg
// Shared definitions for the APB UART front end: register offsets (word index
// taken from paddr[3:2]), STATUS/CTRL bit positions and the TX FSM state type.
// No ports.
// -----------------------------------------------------------------------------
package tmcu_pkg;

    // Register word index (paddr[3:2])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_BUSY    = 5;
    localparam int STATUS_W      = 6;

    // CTRL bit positions
    localparam int CTRL_TX_EN        = 0;
    localparam int CTRL_RX_EN        = 1;
    localparam int CTRL_IRQ_TX_EMPTY = 2;
    localparam int CTRL_IRQ_RX       = 3;
    localparam int CTRL_W            = 4;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_HOLD = 2'd2
    } tx_state_e;

endpackage : tmcu_pkg

// File: rtl/tmcu_sync_fifo.sv
// -----------------------------------------------------------------------------
// tmcu_sync_fifo
// Single-clock FIFO, DEPTH entries (power of two), wrapping pointers of
// log2(DEPTH) bits and an occupancy count of log2(DEPTH)+1 bits.
// A pop on an empty FIFO is ignored. A push on a full FIFO is accepted only
// when a pop happens in the same cycle (the pop frees the slot first).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     write request and data
//   pop               read request; rd_data shows the head combinationally
//   full, empty       occupancy flags
//   count             number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module tmcu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the cleared count
    // already marks every entry invalid, and a reset here would turn the
    // array into plain flops instead of a RAM-friendly structure.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule : tmcu_sync_fifo

// File: rtl/tmcu_apb_uart.sv
// -----------------------------------------------------------------------------
// tmcu_apb_uart
// APB register front end for tmcu_uart with TX/RX byte FIFOs, a three-state
// TX launcher and a registered level interrupt.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   psel, penable, pwrite, paddr,
//   pwdata                           APB slave request
//   prdata, pready, pslverr          APB slave response (zero wait states)
//   uart_tx_start, uart_tx_data      one-cycle byte launch toward tmcu_uart
//   uart_tx_ready                    tmcu_uart idle
//   uart_rx_valid, uart_rx_data      received byte strobe and data
//   irq                              level interrupt
//
// Registers (paddr[3:2]): DATA, STATUS (bit4 W1C), CTRL, reserved.
// -----------------------------------------------------------------------------
module tmcu_apb_uart
    import tmcu_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        uart_tx_start,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e           state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                rx_ovr_q, rx_ovr_d;
    logic                irq_q, irq_d;

    logic                sel_hit, access;
    logic [1:0]          reg_sel;
    logic                data_wr, data_rd;
    logic                tx_pop, tx_full, tx_empty, tx_drop, tx_busy;
    logic                rx_push, rx_full, rx_empty, rx_ovr_set, rx_ovr_clr;
    logic [7:0]          tx_head, rx_head;
    logic [CNT_W-1:0]    tx_count, rx_count;
    logic [STATUS_W-1:0] status;
    logic                unused_bits;

    // ---------------- APB decode ----------------
    assign sel_hit = psel && (paddr[31:12] == BASE_ADDR[31:12]);
    assign access  = sel_hit && penable;
    assign reg_sel = paddr[3:2];
    assign data_wr = access && pwrite  && (reg_sel == REG_DATA);
    assign data_rd = access && !pwrite && (reg_sel == REG_DATA);
    assign pready  = 1'b1;

    // A write to a full TX FIFO still lands if the launcher frees a slot in
    // the same cycle; only a genuinely dropped byte is flagged.
    assign tx_drop = data_wr && tx_full && !tx_pop;
    assign pslverr = access && ((reg_sel == REG_RSVD) || tx_drop);

    // ---------------- FIFOs ----------------
    assign tx_pop  = (state_q == TX_SEND);
    assign rx_push = uart_rx_valid && ctrl_q[CTRL_RX_EN];

    tmcu_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (data_wr),
        .wr_data (pwdata[7:0]),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    tmcu_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (rx_push),
        .wr_data (uart_rx_data),
        .pop     (data_rd),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    // A full RX FIFO being read in the same cycle accepts the new byte.
    assign rx_ovr_set = rx_push && rx_full && !data_rd;
    assign rx_ovr_clr = access && pwrite && (reg_sel == REG_STATUS) && pwdata[ST_RX_OVERRUN];

    // ---------------- TX launcher ----------------
    assign tx_busy       = (state_q != TX_IDLE);
    assign uart_tx_start = (state_q == TX_SEND);
    assign uart_tx_data  = uart_tx_start ? tx_head : 8'h00;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE: if (ctrl_q[CTRL_TX_EN] && !tx_empty && uart_tx_ready) state_d = TX_SEND;
            TX_SEND: state_d = TX_HOLD;
            // tx_en is not consulted here: a byte in flight always completes.
            TX_HOLD: if (uart_tx_ready) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // ---------------- Registers and interrupt ----------------
    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = tx_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_RX_EMPTY]   = rx_empty;
        status[ST_RX_OVERRUN] = rx_ovr_q;
        status[ST_TX_BUSY]    = tx_busy;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (access && pwrite && (reg_sel == REG_CTRL)) ctrl_d = pwdata[CTRL_W-1:0];

        // Set has priority over the W1C clear.
        rx_ovr_d = rx_ovr_q;
        if (rx_ovr_clr) rx_ovr_d = 1'b0;
        if (rx_ovr_set) rx_ovr_d = 1'b1;

        irq_d = (ctrl_q[CTRL_IRQ_TX_EMPTY] && tx_empty && !tx_busy)
              || (ctrl_q[CTRL_IRQ_RX] && !rx_empty)
              || rx_ovr_q;
    end

    always_comb begin
        prdata = '0;
        if (sel_hit && !pwrite) begin
            unique case (reg_sel)
                REG_DATA:   if (!rx_empty) prdata[7:0] = rx_head;
                REG_STATUS: prdata[STATUS_W-1:0] = status;
                REG_CTRL:   prdata[CTRL_W-1:0]   = ctrl_q;
                default:    prdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TX_IDLE;
            ctrl_q   <= '0;
            rx_ovr_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            rx_ovr_q <= rx_ovr_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

    // Address/data bits outside the register map and the FIFO counts are
    // intentionally not used by this block.
    assign unused_bits = ^{paddr[11:4], paddr[1:0], pwdata[31:8], tx_count, rx_count};

endmodule : tmcu_apb_uart

// File: tb/tb_tmcu_apb_uart.sv
// -----------------------------------------------------------------------------
// tb_tmcu_apb_uart
// Directed sequence with randomized bytes for tmcu_apb_uart. A queue-based
// model tracks FIFO contents and sticky flags; a UART model answers start
// pulses by dropping uart_tx_ready for hold_cycles and records launched bytes.
// -----------------------------------------------------------------------------
module tb_tmcu_apb_uart;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_CTRL = 32'h8;
    localparam logic [31:0] A_RSV  = 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready = 1'b1;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        irq;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          hold_cycles = 10;
    int          bad_start = 0;
    logic [7:0]  cap[$];
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    bit          ovr;
    logic [31:0] rd;
    logic        err;
    logic [7:0]  b;
    int          k;

    always #5 clk = ~clk;

    tmcu_apb_uart #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .psel          (psel),
        .penable       (penable),
        .pwrite        (pwrite),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .prdata        (prdata),
        .pready        (pready),
        .pslverr       (pslverr),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .irq           (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // STATUS as the register map defines it, from model occupancy and flags.
    function automatic logic [31:0] model_status(int tx_n, int rx_n, bit ov, bit busy);
        logic [31:0] s;
        s    = '0;
        s[0] = (tx_n == DEPTH);
        s[1] = (tx_n == 0);
        s[2] = (rx_n == DEPTH);
        s[3] = (rx_n == 0);
        s[4] = ov;
        s[5] = busy;
        return s;
    endfunction

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic slverr);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rdata  = prdata;
        slverr = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(posedge clk); #1;
        uart_rx_valid = 1'b1; uart_rx_data = d;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
    endtask

    task automatic wait_cap(input int n, input string tag);
        int budget;
        budget = 2000;
        while (cap.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(tag, cap.size(), n);
    endtask

    // UART model: record each launched byte, then hold ready low.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_tx_start === 1'b1) begin
                cap.push_back(uart_tx_data);
                if (uart_tx_ready !== 1'b1) bad_start++;
                @(posedge clk); #1 uart_tx_ready = 1'b0;
                repeat (hold_cycles) @(posedge clk);
                #1 uart_tx_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; uart_rx_valid = 1'b0; uart_rx_data = '0;
        ovr = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start", uart_tx_start, 0);
        check("rst_tx_data", uart_tx_data, 0);
        check("rst_irq", irq, 0);
        check("rst_pslverr", pslverr, 0);
        check("rst_prdata", prdata, 0);
        check("rst_pready", pready, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        apb(0, A_STAT, 0, rd, err); check("status_after_reset", rd, model_status(0, 0, 0, 0));
        apb(0, A_CTRL, 0, rd, err); check("ctrl_after_reset", rd, 0);

        // ---- CTRL width, reserved slot, address decode ----
        apb(1, A_CTRL, 32'hFFFF_FFF5, rd, err); check("ctrl_wr_err", err, 0);
        apb(0, A_CTRL, 0, rd, err);             check("ctrl_rd_masked", rd, 32'h5);
        apb(1, A_RSV, 32'hF, rd, err);          check("rsv_wr_err", err, 1);
        apb(0, A_RSV, 0, rd, err);              check("rsv_rd_err", err, 1);
        check("rsv_rd_data", rd, 0);
        apb(1, 32'h0000_1008, 32'h2, rd, err);  check("other_window_err", err, 0);
        apb(0, 32'h0000_000B, 0, rd, err);      check("ctrl_unchanged_low_bits", rd, 32'h5);

        // ---- two bytes with a slow UART ----
        apb(1, A_CTRL, 32'h1, rd, err);
        hold_cycles = 10;
        apb(1, A_DATA, 32'h55, rd, err); check("tx55_err", err, 0);
        apb(1, A_DATA, 32'hA3, rd, err); check("txA3_err", err, 0);
        wait_cap(2, "tx_two_bytes");
        if (cap.size() >= 2) begin
            check("tx_byte0", cap[0], 8'h55);
            check("tx_byte1", cap[1], 8'hA3);
        end
        cap.delete();
        repeat (15) @(posedge clk);

        // ---- random bytes, random UART hold ----
        txq.delete();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            hold_cycles = $urandom_range(0, 3);
            txq.push_back(b);
            apb(1, A_DATA, {24'h0, b}, rd, err);
            check($sformatf("rand_tx_err%0d", i), err, 0);
            repeat (4) @(posedge clk);
        end
        wait_cap(12, "rand_tx_count");
        for (int i = 0; i < 12 && i < cap.size(); i++)
            check($sformatf("rand_tx_byte%0d", i), cap[i], txq[i]);
        cap.delete(); txq.delete();
        repeat (10) @(posedge clk);

        // ---- TX FIFO overflow with tx_en=0 ----
        apb(1, A_CTRL, 32'h0, rd, err);
        apb(0, A_STAT, 0, rd, err); check("tx_idle_status", rd, model_status(0, 0, 0, 0));
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            apb(1, A_DATA, {24'h0, b}, rd, err);
            check($sformatf("fill_err%0d", i), err, (txq.size() == DEPTH) ? 1'b1 : 1'b0);
            if (txq.size() < DEPTH) txq.push_back(b);
        end
        apb(0, A_STAT, 0, rd, err); check("tx_full_status", rd, model_status(DEPTH, 0, 0, 0));
        hold_cycles = 1;
        apb(1, A_CTRL, 32'h1, rd, err);
        wait_cap(DEPTH, "drain_count");
        for (int i = 0; i < DEPTH && i < cap.size(); i++)
            check($sformatf("drain_byte%0d", i), cap[i], txq[i]);
        cap.delete(); txq.delete();
        repeat (10) @(posedge clk);

        // ---- clearing tx_en mid-byte finishes that byte only ----
        apb(1, A_CTRL, 32'h0, rd, err);
        apb(1, A_DATA, 32'h3C, rd, err);
        apb(1, A_DATA, 32'hC3, rd, err);
        hold_cycles = 10;
        apb(1, A_CTRL, 32'h1, rd, err);
        wait_cap(1, "midbyte_first");
        apb(1, A_CTRL, 32'h0, rd, err);
        repeat (30) @(posedge clk);
        check("midbyte_no_more", cap.size(), 1);
        apb(0, A_STAT, 0, rd, err); check("midbyte_status", rd, model_status(1, 0, 0, 0));
        apb(1, A_CTRL, 32'h1, rd, err);
        wait_cap(2, "midbyte_resume");
        if (cap.size() >= 2) begin
            check("midbyte_b0", cap[0], 8'h3C);
            check("midbyte_b1", cap[1], 8'hC3);
        end
        cap.delete();
        repeat (15) @(posedge clk);

        // ---- RX: disabled drops, random fill and readback ----
        apb(1, A_CTRL, 32'h0, rd, err);
        rx_pulse(8'h99);
        apb(0, A_STAT, 0, rd, err); check("rx_disabled_drop", rd, model_status(0, 0, 0, 0));
        apb(1, A_CTRL, 32'h2, rd, err);
        k = $urandom_range(1, DEPTH);
        for (int i = 0; i < k; i++) begin
            b = 8'($urandom);
            rxq.push_back(b);
            rx_pulse(b);
        end
        apb(0, A_STAT, 0, rd, err); check("rx_rand_status", rd, model_status(0, rxq.size(), 0, 0));
        for (int i = 0; i < k; i++) begin
            apb(0, A_DATA, 0, rd, err);
            check($sformatf("rx_rand_byte%0d", i), rd, {24'h0, rxq.pop_front()});
        end

        // ---- RX overrun ----
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'(8'h10 + i);
            if (rxq.size() < DEPTH) rxq.push_back(b); else ovr = 1'b1;
            rx_pulse(b);
        end
        apb(0, A_STAT, 0, rd, err); check("ovr_status", rd, model_status(0, rxq.size(), ovr, 0));
        for (int i = 0; i < DEPTH + 1; i++) begin
            apb(0, A_DATA, 0, rd, err);
            check($sformatf("ovr_rd%0d", i), rd, (rxq.size() > 0) ? {24'h0, rxq.pop_front()} : 32'h0);
            check($sformatf("ovr_rd_err%0d", i), err, 0);
        end
        apb(0, A_STAT, 0, rd, err); check("ovr_empty_status", rd, model_status(0, 0, ovr, 0));
        apb(1, A_STAT, 32'h10, rd, err); ovr = 1'b0;
        apb(0, A_STAT, 0, rd, err); check("ovr_w1c", rd, model_status(0, 0, ovr, 0));

        // ---- W1C coinciding with a new overrun: set wins ----
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            rxq.push_back(b);
            rx_pulse(b);
        end
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_STAT; pwdata = 32'h10;
        @(posedge clk); #1;
        penable = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'hEE;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; uart_rx_valid = 1'b0;
        ovr = 1'b1;
        apb(0, A_STAT, 0, rd, err); check("set_wins", rd, model_status(0, rxq.size(), ovr, 0));
        apb(1, A_STAT, 32'h10, rd, err); ovr = 1'b0;
        apb(0, A_STAT, 0, rd, err); check("set_then_clear", rd, model_status(0, rxq.size(), ovr, 0));
        while (rxq.size() > 0) begin
            apb(0, A_DATA, 0, rd, err);
            check("set_wins_drain", rd, {24'h0, rxq.pop_front()});
        end

        // ---- interrupt timing ----
        @(negedge clk); check("irq_idle", irq, 0);
        apb(1, A_CTRL, 32'hF, rd, err);
        @(negedge clk); check("irq_lag", irq, 0);
        @(negedge clk); check("irq_tx_empty", irq, 1);
        apb(1, A_CTRL, 32'hA, rd, err);
        @(negedge clk); @(negedge clk); check("irq_off", irq, 0);
        b = 8'($urandom);
        rx_pulse(b);
        @(negedge clk); check("irq_rx_lag", irq, 0);
        @(negedge clk); check("irq_rx", irq, 1);
        apb(0, A_DATA, 0, rd, err); check("irq_rx_byte", rd, {24'h0, b});
        @(negedge clk); check("irq_rx_hold", irq, 1);
        @(negedge clk); check("irq_rx_clear", irq, 0);

        // ---- reset while a byte is held with three queued ----
        apb(1, A_CTRL, 32'h0, rd, err);
        hold_cycles = 10;
        for (int i = 0; i < 4; i++) apb(1, A_DATA, 32'h60 + i, rd, err);
        apb(1, A_CTRL, 32'h1, rd, err);
        wait_cap(1, "rst_first_byte");
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx_start", uart_tx_start, 0);
        check("midrst_tx_data", uart_tx_data, 0);
        check("midrst_irq", irq, 0);
        check("midrst_prdata", prdata, 0);
        check("midrst_pready", pready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        check("rst_no_start", cap.size(), 1);
        apb(0, A_STAT, 0, rd, err); check("rst_status", rd, model_status(0, 0, 0, 0));
        apb(0, A_CTRL, 0, rd, err); check("rst_ctrl", rd, 0);

        check("start_while_not_ready", bad_start, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_tmcu_apb_uart
